// File: rtl/sdram_init_monitor.sv
// Watches the controller's SDRAM command bus through the power-up/init sequence and flags illegal order or timing.
// Optional macro SDRAM_MON_TIMING_CHK_EN: reject any non-NOP inside the tRP/tRFC/tMRD windows (err_code 4).
module sdram_init_monitor #(
    parameter int POWERUP_CYCLES = 10000,
    parameter int TRP_CYCLES     = 2,
    parameter int TRFC_CYCLES    = 4,
    parameter int TMRD_CYCLES    = 2,
    parameter int REF_NUM        = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sdram_cmd,
    input  logic [11:0] sdram_addr,
    output logic        dev_ready,
    output logic        init_err,
    output logic [2:0]  err_code,
    output logic [3:0]  ref_cnt,
    output logic [11:0] mode_reg,
    output logic [3:0]  burst_len,
    output logic [1:0]  cas_lat
);
    localparam int MAX_A   = (POWERUP_CYCLES > TRFC_CYCLES) ? POWERUP_CYCLES : TRFC_CYCLES;
    localparam int MAX_B   = (TRP_CYCLES > TMRD_CYCLES) ? TRP_CYCLES : TMRD_CYCLES;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [3:0] REF_NUM_W = 4'(REF_NUM);

    typedef enum logic [2:0] {
        PWR_WAIT, WAIT_PRE, T_RP, WAIT_REF, T_RFC, T_MRD, READY, ERROR
    } state_t;

    state_t          r_state, w_nxt_state;
    logic [CW-1:0]   r_cnt, w_nxt_cnt;
    logic            r_dev_ready, r_init_err;
    logic [2:0]      r_err_code, w_err_code;
    logic [3:0]      r_ref_cnt;
    logic [11:0]     r_mode_reg;
    logic [3:0]      r_burst_len, w_burst;
    logic [1:0]      r_cas_lat;
    logic            w_ref_inc, w_latch, w_win_bad;
    logic            w_nop, w_pre, w_aref, w_mrs, w_mode_bad;

    // DESELECT (cs_n=1) behaves exactly like NOP
    assign w_nop  = sdram_cmd[3] | (sdram_cmd == 4'b0111);
    assign w_pre  = (sdram_cmd == 4'b0010);
    assign w_aref = (sdram_cmd == 4'b0001);
    assign w_mrs  = (sdram_cmd == 4'b0000);

    assign w_mode_bad = sdram_addr[6] | ~sdram_addr[5] |
                        (sdram_addr[2:0] >= 3'd4 && sdram_addr[2:0] <= 3'd6);

    always_comb begin
        w_burst = 4'd0;
        case (sdram_addr[2:0])
            3'd0:    w_burst = 4'd1;
            3'd1:    w_burst = 4'd2;
            3'd2:    w_burst = 4'd4;
            3'd3:    w_burst = 4'd8;
            default: w_burst = 4'd0;
        endcase
    end

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = r_cnt;
        w_err_code  = 3'd0;
        w_ref_inc   = 1'b0;
        w_latch     = 1'b0;
        w_win_bad   = 1'b0;
        case (r_state)
            // the command may land on the POWERUP_CYCLES-th sampled cycle
            PWR_WAIT: begin
                if (!w_nop) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd1;
                end else if (r_cnt <= CW'(2)) begin
                    w_nxt_state = WAIT_PRE;
                end else begin
                    w_nxt_cnt = r_cnt - CW'(1);
                end
            end
            WAIT_PRE: begin
                if (w_pre && sdram_addr[10]) begin
                    w_nxt_state = (TRP_CYCLES > 1) ? T_RP : WAIT_REF;
                    w_nxt_cnt   = CW'(TRP_CYCLES - 1);
                end else if (w_pre) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd3;
                end else if (!w_nop) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd2;
                end
            end
            WAIT_REF: begin
                if (w_aref) begin
                    w_ref_inc   = 1'b1;
                    w_nxt_state = (TRFC_CYCLES > 1) ? T_RFC : WAIT_REF;
                    w_nxt_cnt   = CW'(TRFC_CYCLES - 1);
                end else if (w_pre && sdram_addr[10]) begin
                    w_nxt_state = (TRP_CYCLES > 1) ? T_RP : WAIT_REF;
                    w_nxt_cnt   = CW'(TRP_CYCLES - 1);
                end else if (w_pre) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd3;
                end else if (w_mrs) begin
                    // too few refreshes outranks a bad mode word
                    if (r_ref_cnt < REF_NUM_W) begin
                        w_nxt_state = ERROR;
                        w_err_code  = 3'd2;
                    end else if (w_mode_bad) begin
                        w_nxt_state = ERROR;
                        w_err_code  = 3'd5;
                    end else begin
                        w_latch     = 1'b1;
                        w_nxt_state = T_MRD;
                        w_nxt_cnt   = CW'(TMRD_CYCLES);
                    end
                end else if (!w_nop) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd2;
                end
            end
            T_RP, T_RFC, T_MRD: begin
`ifdef SDRAM_MON_TIMING_CHK_EN
                w_win_bad = !w_nop;
`else
                w_ref_inc = w_aref;
`endif
                if (w_win_bad) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd4;
                end else if (r_cnt <= CW'(1)) begin
                    w_nxt_state = (r_state == T_MRD) ? READY : WAIT_REF;
                end else begin
                    w_nxt_cnt = r_cnt - CW'(1);
                end
            end
            READY: begin
                w_ref_inc = w_aref;
                if (w_mrs && w_mode_bad) begin
                    w_nxt_state = ERROR;
                    w_err_code  = 3'd5;
                end else if (w_mrs) begin
                    w_latch = 1'b1;
                end
            end
            default: w_nxt_state = ERROR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= PWR_WAIT;
            r_cnt       <= CW'(POWERUP_CYCLES);
            r_dev_ready <= 1'b0;
            r_init_err  <= 1'b0;
            r_err_code  <= 3'd0;
            r_ref_cnt   <= 4'd0;
            r_mode_reg  <= 12'd0;
            r_burst_len <= 4'd0;
            r_cas_lat   <= 2'd0;
        end else begin
            r_state     <= w_nxt_state;
            r_cnt       <= w_nxt_cnt;
            r_dev_ready <= (w_nxt_state == READY);
            r_init_err  <= (w_nxt_state == ERROR);
            if (w_nxt_state == ERROR && r_state != ERROR)
                r_err_code <= w_err_code;
            if (w_ref_inc && r_ref_cnt != 4'hF)
                r_ref_cnt <= r_ref_cnt + 4'd1;
            if (w_latch) begin
                r_mode_reg  <= sdram_addr;
                r_burst_len <= w_burst;
                r_cas_lat   <= sdram_addr[5:4];
            end
        end
    end

    assign dev_ready = r_dev_ready;
    assign init_err  = r_init_err;
    assign err_code  = r_err_code;
    assign ref_cnt   = r_ref_cnt;
    assign mode_reg  = r_mode_reg;
    assign burst_len = r_burst_len;
    assign cas_lat   = r_cas_lat;
endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: directed init scenarios with randomized NOP/DESELECT encodings and
// READY-phase traffic, every cycle compared against a timestamp-based model of the init rules.
module tb_sdram_init_monitor;
    localparam int PU = 10000, TRP = 2, TRFC = 4, TMRD = 2, REFN = 8;
    localparam logic [3:0] C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic [3:0]  sdram_cmd = C_NOP;
    logic [11:0] sdram_addr = 12'd0;
    logic        dev_ready, init_err;
    logic [2:0]  err_code;
    logic [3:0]  ref_cnt, burst_len;
    logic [11:0] mode_reg;
    logic [1:0]  cas_lat;

    sdram_init_monitor #(.POWERUP_CYCLES(PU), .TRP_CYCLES(TRP), .TRFC_CYCLES(TRFC),
                         .TMRD_CYCLES(TMRD), .REF_NUM(REFN)) dut (
        .clk(clk), .rst_n(rst_n), .sdram_cmd(sdram_cmd), .sdram_addr(sdram_addr),
        .dev_ready(dev_ready), .init_err(init_err), .err_code(err_code), .ref_cnt(ref_cnt),
        .mode_reg(mode_reg), .burst_len(burst_len), .cas_lat(cas_lat));

    always #5 clk = ~clk;

    int n_pass = 0, n_fail = 0, n_chk = 0;

    // model state: time since reset, phase (0 want precharge, 1 refreshing, 2 ready),
    // first cycle a command is honoured again, cycle at which dev_ready must be up
    int          m_t, m_phase, m_busy, m_ready_at, m_refs;
    bit          m_err;
    logic [2:0]  m_code;
    logic [11:0] m_mode;
    logic [3:0]  m_bl;
    logic [1:0]  m_cl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s t=%0d obs=%0h exp=%0h", tag, m_t, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        m_t = 0; m_phase = 0; m_busy = 0; m_ready_at = 0; m_refs = 0;
        m_err = 0; m_code = 0; m_mode = 0; m_bl = 0; m_cl = 0;
    endtask

    task automatic m_fail(input int code);
        m_err = 1; m_code = 3'(code);
    endtask

    function automatic bit bad_mode(input logic [11:0] a);
        return a[6] || a[5:4] < 2 || (a[2:0] >= 4 && a[2:0] <= 6);
    endfunction

    task automatic m_latch(input logic [11:0] a);
        m_mode = a;
        m_bl   = (a[2:0] == 3'd7) ? 4'd0 : 4'(1 << a[2:0]);
        m_cl   = a[5:4];
    endtask

    task automatic mdl_step(input logic [3:0] c, input logic [11:0] a);
        bit nop;
        m_t++;
        if (m_err) return;
        nop = c[3] || c == C_NOP;
        if (m_t < PU) begin
            if (!nop) m_fail(1);
            return;
        end
        if (m_t < m_busy) begin
`ifdef SDRAM_MON_TIMING_CHK_EN
            if (!nop) m_fail(4);
`else
            if (c == C_REF) m_refs++;
`endif
            return;
        end
        if (nop) return;
        if (m_phase == 0) begin
            if (c == C_PRE && a[10]) begin m_phase = 1; m_busy = m_t + TRP; end
            else if (c == C_PRE) m_fail(3);
            else m_fail(2);
        end else if (m_phase == 1) begin
            if (c == C_PRE) begin
                if (a[10]) m_busy = m_t + TRP; else m_fail(3);
            end else if (c == C_REF) begin
                m_refs++; m_busy = m_t + TRFC;
            end else if (c == C_MRS) begin
                if (m_refs < REFN) m_fail(2);
                else if (bad_mode(a)) m_fail(5);
                else begin
                    m_latch(a); m_phase = 2;
                    m_ready_at = m_t + TMRD; m_busy = m_t + TMRD + 1;
                end
            end else m_fail(2);
        end else begin
            if (c == C_REF) m_refs++;
            else if (c == C_MRS) begin
                if (bad_mode(a)) m_fail(5); else m_latch(a);
            end
        end
    endtask

    task automatic chk_model();
        logic exp_rdy;
        logic [3:0] exp_ref;
        exp_rdy = !m_err && m_phase == 2 && m_t >= m_ready_at;
        exp_ref = (m_refs > 15) ? 4'd15 : 4'(m_refs);
        chk("model", {5'd0, dev_ready, init_err, err_code, ref_cnt, mode_reg, burst_len, cas_lat},
            {5'd0, exp_rdy, m_err, m_code, exp_ref, m_mode, m_bl, m_cl});
    endtask

    task automatic step(input logic [3:0] c, input logic [11:0] a);
        sdram_cmd = c; sdram_addr = a;
        @(posedge clk); #1;
        mdl_step(c, a);
        chk_model();
    endtask

    function automatic logic [3:0] rnd_nop();
        return ($urandom_range(0, 1) == 1) ? C_NOP : {1'b1, 3'($urandom)};
    endfunction

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) step(rnd_nop(), 12'($urandom));
    endtask

    function automatic logic [11:0] mrs_good();
        int k;
        k = $urandom_range(0, 4);
        return {5'($urandom), 1'b0, 1'b1, 1'($urandom), 1'($urandom), (k == 4) ? 3'd7 : 3'(k)};
    endfunction

    // asynchronous: outputs must clear without waiting for an edge
    task automatic apply_reset(input string tag);
        rst_n = 1'b0; sdram_cmd = C_NOP; #1;
        mdl_reset();
        chk({tag, "_rdy"}, 32'(dev_ready), 32'd0);
        chk({tag, "_err"}, 32'(init_err), 32'd0);
        chk({tag, "_code"}, 32'(err_code), 32'd0);
        chk({tag, "_ref"}, 32'(ref_cnt), 32'd0);
        chk({tag, "_mode"}, 32'(mode_reg), 32'd0);
        chk({tag, "_bl"}, 32'(burst_len), 32'd0);
        chk({tag, "_cl"}, 32'(cas_lat), 32'd0);
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic legal_init(input int nref);
        nops(PU - 1);
        step(C_PRE, 12'h400);
        nops(1);
        repeat (nref) begin
            step(C_REF, 12'($urandom));
            nops(3);
        end
    endtask

    initial begin
        int r;
        // early command during power-up
        apply_reset("rst0");
        nops(99);
        step(C_REF, 12'h000);
        chk("r020_err", 32'(init_err), 32'd1);
        chk("r020_code", 32'(err_code), 32'd1);
        chk("r020_rdy", 32'(dev_ready), 32'd0);
        nops(3);
        step(C_PRE, 12'h400);
        chk("r020_frozen", 32'(err_code), 32'd1);

        // full legal sequence then random READY-phase traffic
        apply_reset("rst1");
        legal_init(8);
        step(C_MRS, 12'h032);
        chk("r019_rdy_mrs", 32'(dev_ready), 32'd0);
        nops(1);
        chk("r019_rdy_p1", 32'(dev_ready), 32'd0);
        nops(1);
        chk("r019_rdy_p2", 32'(dev_ready), 32'd1);
        chk("r019_bl", 32'(burst_len), 32'd4);
        chk("r019_cl", 32'(cas_lat), 32'd3);
        chk("r019_ref", 32'(ref_cnt), 32'd8);
        chk("r019_err", 32'(init_err), 32'd0);
        chk("r019_mode", 32'(mode_reg), 32'h032);
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 15);
            if (r < 6) step(rnd_nop(), 12'($urandom));
            else if (r < 10) step(C_REF, 12'($urandom));
            else if (r < 11) step(C_PRE, 12'($urandom));
            else if (r < 13) step(C_MRS, mrs_good());
            else if (r < 15) step(4'($urandom_range(3, 6)), 12'($urandom));
            else step(C_MRS, ($urandom_range(0, 3) == 0) ? 12'($urandom) : mrs_good());
        end

        // PRECHARGE one cycle early: power-up window still open
        apply_reset("rst2");
        nops(PU - 2);
        step(C_PRE, 12'h400);
        chk("pu_edge_code", 32'(err_code), 32'd1);

        // precharge without A10
        apply_reset("rst3");
        nops(PU - 1);
        step(C_PRE, 12'h000);
        chk("r021a_code", 32'(err_code), 32'd3);
        chk("r021a_rdy", 32'(dev_ready), 32'd0);

        // MRS after only 7 refreshes
        apply_reset("rst4");
        legal_init(7);
        step(C_MRS, 12'h032);
        chk("r021b_code", 32'(err_code), 32'd2);
        chk("r021b_err", 32'(init_err), 32'd1);
        chk("r021b_ref", 32'(ref_cnt), 32'd7);

        // back-to-back AUTO_REF, then an MRS with CL=1
        apply_reset("rst5");
        nops(PU - 1);
        step(C_PRE, 12'h400);
        nops(1);
        step(C_REF, 12'h000);
        step(C_REF, 12'h000);
`ifdef SDRAM_MON_TIMING_CHK_EN
        chk("r022_code", 32'(err_code), 32'd4);
`else
        chk("r022_ref", 32'(ref_cnt), 32'd2);
        chk("r022_err", 32'(init_err), 32'd0);
`endif
        nops(3);
        repeat (6) begin step(C_REF, 12'h000); nops(3); end
        step(C_MRS, 12'h012);
`ifdef SDRAM_MON_TIMING_CHK_EN
        chk("r023_code", 32'(err_code), 32'd4);
`else
        chk("r023_code", 32'(err_code), 32'd5);
`endif
        chk("r023_mode", 32'(mode_reg), 32'd0);
        chk("r023_bl", 32'(burst_len), 32'd0);
        chk("r023_cl", 32'(cas_lat), 32'd0);
        chk("r023_rdy", 32'(dev_ready), 32'd0);

        // reset pulse during the fifth refresh, then a clean restart
        apply_reset("rst6");
        legal_init(4);
        step(C_REF, 12'h000);
        nops(1);
        chk("r024_pre_ref", 32'(ref_cnt), 32'd5);
        apply_reset("r024");
        legal_init(8);
        step(C_MRS, 12'h032);
        nops(2);
        chk("r024_rdy", 32'(dev_ready), 32'd1);
        chk("r024_ref", 32'(ref_cnt), 32'd8);
        chk("r024_bl", 32'(burst_len), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
